// File: rtl/gate_sweeper.sv
// gate_sweeper: clocked four-minterm sweep of a 2-input combinational gate,
// capturing its truth table and comparing it against an expected mask.
module gate_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       s,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [3:0] mismatch,
  output logic       pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  localparam logic [3:0] LAST =
    4'(SETTLE == 0 ? 0 : SETTLE - 1);

  state_t     state, state_d;
  logic [3:0] wcnt, wcnt_d;
  logic [1:0] m;
  logic [3:0] exp_q;
  logic [3:0] res_nxt;
  logic       accept, fire;

  // SETTLE=0 skips the wait state entirely
  function automatic state_t after_apply();
    return (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    accept  = 1'b0;
    fire    = 1'b0;
    res_nxt = result;
    res_nxt[m] = s;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          wcnt_d  = '0;
          state_d = after_apply();
        end
      end
      S_SETTLE: begin
        if (wcnt == LAST) begin
          wcnt_d  = '0;
          state_d = S_SAMPLE;
        end else begin
          wcnt_d = wcnt + 4'd1;
        end
      end
      S_SAMPLE: begin
        fire = 1'b1;
        if (m == 2'd3) state_d = S_IDLE;
        else           state_d = after_apply();
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m        <= '0;
      exp_q    <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        exp_q    <= expected;
        m        <= '0;
        {a, b}   <= 2'b00;
        busy     <= 1'b1;
        result   <= '0;
        mismatch <= '0;
        pass     <= 1'b0;
      end else if (fire) begin
        result <= res_nxt;
        if (m == 2'd3) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          {a, b}   <= 2'b00;
          mismatch <= res_nxt ^ exp_q;
          pass     <= (res_nxt == exp_q);
        end else begin
          m      <= m + 2'd1;
          {a, b} <= m + 2'd1;
        end
      end
    end
  end

endmodule
